// File: rtl/serializer_lane_scheduler_if.sv
// Lane scheduler bus: requester words in, one serializer word per slot out.
// master drives the requester side; slave is the scheduler itself.
interface serializer_lane_scheduler_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 16
);
   localparam int SW = $clog2(NREQ);

   logic                  enable_i;
   logic [NREQ-1:0]       req_valid_i;
   logic [NREQ*WIDTH-1:0] req_data_i;
   logic [NREQ-1:0]       req_ready_o;
   logic [WIDTH-1:0]      word_o;
   logic                  word_load_o;
   logic [SW-1:0]         word_src_o;
   logic                  word_idle_o;
   logic                  busy_o;

   modport master (
      output enable_i, req_valid_i, req_data_i,
      input  req_ready_o, word_o, word_load_o,
      input  word_src_o, word_idle_o, busy_o
   );

   modport slave (
      input  enable_i, req_valid_i, req_data_i,
      output req_ready_o, word_o, word_load_o,
      output word_src_o, word_idle_o, busy_o
   );
endinterface

// File: rtl/serializer_lane_scheduler.sv
// Round-robin word-slot scheduler feeding a WIDTH-to-1 serializer.
// SERIALIZER_SYNC_INSERT_EN adds a SYNC_WORD slot every SYNC_PERIOD slots.
module serializer_lane_scheduler #(
   parameter int NREQ = 4,
   parameter int WIDTH = 16,
   parameter logic [WIDTH-1:0] IDLE_WORD = '0
`ifdef SERIALIZER_SYNC_INSERT_EN
   ,
   parameter logic [WIDTH-1:0] SYNC_WORD = WIDTH'(16'hA5C3),
   parameter int SYNC_PERIOD = 64
`endif
) (
   input logic clk,
   input logic reset,
   serializer_lane_scheduler_if.slave lane
);
   localparam int SW = $clog2(NREQ);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic {OFF, RUN} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [SW-1:0]    ptr;
   logic [WIDTH-1:0] word_q;
   logic             load_q;
   logic             idle_q;
   logic [SW-1:0]    src_q;

   logic             slot_end;
   logic             sync_due;
   logic             arb_en;
   logic             grant_found;
   logic [SW-1:0]    grant_idx;
   logic [NREQ-1:0]  ready;
   logic [WIDTH-1:0] grant_word;
   logic [WIDTH-1:0] sync_pat;

   assign slot_end = (state == RUN) && (cnt == CNT_LAST);
   assign arb_en   = slot_end && lane.enable_i && !sync_due;

`ifdef SERIALIZER_SYNC_INSERT_EN
   localparam int PW = (SYNC_PERIOD > 1) ? $clog2(SYNC_PERIOD) : 1;
   logic [PW-1:0] sync_cnt;

   assign sync_due = (sync_cnt == PW'(SYNC_PERIOD - 1));
   assign sync_pat = SYNC_WORD;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_cnt <= '0;
      end else if (state != RUN) begin
         sync_cnt <= '0;
      end else if (slot_end) begin
         if (!lane.enable_i || sync_due) sync_cnt <= '0;
         else sync_cnt <= sync_cnt + 1'b1;
      end
   end
`else
   assign sync_due = 1'b0;
   assign sync_pat = IDLE_WORD;
`endif

   // first valid requester after the last one served
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = ptr;
      for (int i = 1; i <= NREQ; i++) begin
         if (!grant_found &&
             lane.req_valid_i[(int'(ptr) + i) % NREQ]) begin
            grant_found = 1'b1;
            grant_idx   = SW'((int'(ptr) + i) % NREQ);
         end
      end
   end

   always_comb begin
      ready = '0;
      if (arb_en && grant_found) ready[grant_idx] = 1'b1;
   end

   assign grant_word = lane.req_data_i[int'(grant_idx)*WIDTH +: WIDTH];

   // RUN is entered on a slot end so the first word loads one cycle later
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= OFF;
         cnt    <= '0;
         ptr    <= SW'(NREQ - 1);
         word_q <= IDLE_WORD;
         idle_q <= 1'b1;
         load_q <= 1'b0;
         src_q  <= '0;
      end else begin
         load_q <= slot_end;
         unique case (state)
            OFF: begin
               cnt <= '0;
               if (lane.enable_i) begin
                  state <= RUN;
                  cnt   <= CNT_LAST;
               end
            end
            RUN: begin
               cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
               if (slot_end) begin
                  if (!lane.enable_i) begin
                     word_q <= IDLE_WORD;
                     idle_q <= 1'b1;
                     state  <= OFF;
                     cnt    <= '0;
                  end else if (sync_due) begin
                     word_q <= sync_pat;
                     idle_q <= 1'b1;
                  end else if (grant_found) begin
                     word_q <= grant_word;
                     idle_q <= 1'b0;
                     src_q  <= grant_idx;
                     ptr    <= grant_idx;
                  end else begin
                     word_q <= IDLE_WORD;
                     idle_q <= 1'b1;
                  end
               end
            end
            default: state <= OFF;
         endcase
      end
   end

   assign lane.req_ready_o = ready;
   assign lane.word_o      = word_q;
   assign lane.word_load_o = load_q;
   assign lane.word_src_o  = src_q;
   assign lane.word_idle_o = idle_q;
   assign lane.busy_o      = (state == RUN);
endmodule

// File: tb/tb_serializer_lane_scheduler.sv
// Bench for serializer_lane_scheduler: slot-level reference model plus
// directed and randomized scenarios.
module tb_serializer_lane_scheduler;
   localparam int N = 4;
   localparam int W = 16;
`ifdef SERIALIZER_SYNC_INSERT_EN
   localparam bit SYNC_EN = 1'b1;
   localparam int SP = 4;
`else
   localparam bit SYNC_EN = 1'b0;
   localparam int SP = 64;
`endif
   localparam logic [W-1:0] IDLE = 16'h0000;
   localparam logic [W-1:0] SYNC = 16'hA5C3;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int n_checks = 0;
   int n_fail = 0;

   serializer_lane_scheduler_if #(.NREQ(N), .WIDTH(W)) lane();

`ifdef SERIALIZER_SYNC_INSERT_EN
   serializer_lane_scheduler #(
      .NREQ(N), .WIDTH(W), .IDLE_WORD(IDLE),
      .SYNC_WORD(SYNC), .SYNC_PERIOD(SP)
   ) dut (.clk(clk), .reset(reset), .lane(lane));
`else
   serializer_lane_scheduler #(
      .NREQ(N), .WIDTH(W), .IDLE_WORD(IDLE)
   ) dut (.clk(clk), .reset(reset), .lane(lane));
`endif

   always #5 clk = ~clk;

   // reference: slot phase = RUN cycles since entry mod W
   bit m_run = 1'b0;
   int m_t = 0;
   int m_ptr = N - 1;
   int m_src = 0;
   int m_sync = 0;
   logic [W-1:0] m_word = IDLE;
   bit m_idle = 1'b1;
   bit m_load = 1'b0;

   always @(negedge clk) begin : mon
      logic [N-1:0] exp_ready;
      bit se;
      bit sy;
      int g;
      if (reset) begin
         m_run = 0; m_t = 0; m_ptr = N - 1; m_src = 0;
         m_sync = 0; m_word = IDLE; m_idle = 1; m_load = 0;
      end
      se = m_run && (m_t % W == 0);
      sy = SYNC_EN && (m_sync == SP - 1);
      g = -1;
      if (se && lane.enable_i && !sy) begin
         for (int o = 1; o <= N; o++) begin
            if (g < 0 && lane.req_valid_i[(m_ptr + o) % N])
               g = (m_ptr + o) % N;
         end
      end
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;

      n_checks += 6;
      if (lane.req_ready_o !== exp_ready) begin
         n_fail++;
         $display("FAIL mon_ready t=%0t got %b exp %b",
                  $time, lane.req_ready_o, exp_ready);
      end
      if (lane.word_o !== m_word) begin
         n_fail++;
         $display("FAIL mon_word t=%0t got %h exp %h",
                  $time, lane.word_o, m_word);
      end
      if (int'(lane.word_src_o) != m_src) begin
         n_fail++;
         $display("FAIL mon_src t=%0t got %0d exp %0d",
                  $time, lane.word_src_o, m_src);
      end
      if (lane.word_idle_o !== m_idle) begin
         n_fail++;
         $display("FAIL mon_idle t=%0t got %b exp %b",
                  $time, lane.word_idle_o, m_idle);
      end
      if (lane.word_load_o !== m_load) begin
         n_fail++;
         $display("FAIL mon_load t=%0t got %b exp %b",
                  $time, lane.word_load_o, m_load);
      end
      if (lane.busy_o !== m_run) begin
         n_fail++;
         $display("FAIL mon_busy t=%0t got %b exp %b",
                  $time, lane.busy_o, m_run);
      end

      if (!reset) begin
         m_load = se;
         if (m_run) begin
            if (se) begin
               if (!lane.enable_i) begin
                  m_word = IDLE; m_idle = 1; m_run = 0; m_sync = 0;
               end else if (sy) begin
                  m_word = SYNC; m_idle = 1; m_sync = 0;
               end else begin
                  m_sync++;
                  if (g >= 0) begin
                     m_word = lane.req_data_i[g*W +: W];
                     m_src = g; m_ptr = g; m_idle = 0;
                  end else begin
                     m_word = IDLE; m_idle = 1;
                  end
               end
            end
            m_t++;
         end else if (lane.enable_i) begin
            m_run = 1; m_t = 0; m_sync = 0;
         end
      end
   end

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      lane.enable_i = 1'b0;
      lane.req_valid_i = '0;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_checks += 6;
      if (lane.word_o !== IDLE) begin
         n_fail++; $display("FAIL rst_word got %h exp %h", lane.word_o, IDLE);
      end
      if (lane.word_idle_o !== 1'b1) begin
         n_fail++; $display("FAIL rst_idle got %b exp 1", lane.word_idle_o);
      end
      if (lane.word_load_o !== 1'b0) begin
         n_fail++; $display("FAIL rst_load got %b exp 0", lane.word_load_o);
      end
      if (lane.word_src_o !== '0) begin
         n_fail++; $display("FAIL rst_src got %0d exp 0", lane.word_src_o);
      end
      if (lane.req_ready_o !== '0) begin
         n_fail++; $display("FAIL rst_ready got %b exp 0", lane.req_ready_o);
      end
      if (lane.busy_o !== 1'b0) begin
         n_fail++; $display("FAIL rst_busy got %b exp 0", lane.busy_o);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_idle_slots();
      int pos[$];
      int c;
      bit rdy_seen;
      do_reset();
      lane.enable_i = 1'b1;
      c = 0;
      rdy_seen = 0;
      @(negedge clk);
      while (!lane.busy_o && c < 20) begin
         @(negedge clk);
         c++;
      end
      n_checks++;
      if (!lane.busy_o) begin
         n_fail++; $display("FAIL idle_busy_timeout got 0 exp 1");
      end
      for (int k = 0; k < 41; k++) begin
         if (k > 0) @(negedge clk);
         if (|lane.req_ready_o) rdy_seen = 1;
         if (lane.word_load_o) begin
            pos.push_back(k);
            n_checks++;
            if (lane.word_o !== IDLE || lane.word_idle_o !== 1'b1) begin
               n_fail++;
               $display("FAIL idle_word got %h/%b exp %h/1",
                        lane.word_o, lane.word_idle_o, IDLE);
            end
         end
      end
      n_checks += 2;
      if (pos.size() != 3 || pos[0] != 1 || pos[1] != 17 || pos[2] != 33) begin
         n_fail++;
         $display("FAIL idle_strobe_pos got n=%0d exp 1,17,33", pos.size());
      end
      if (rdy_seen) begin
         n_fail++; $display("FAIL idle_ready got 1 exp 0");
      end
   endtask

   task automatic test_single_req();
      int c;
      do_reset();
      lane.req_valid_i = 4'b0100;
      lane.req_data_i[2*W +: W] = 16'h1234;
      lane.enable_i = 1'b1;
      c = 0;
      @(negedge clk);
      while (lane.req_ready_o == '0 && c < 40) begin
         @(negedge clk);
         c++;
      end
      n_checks++;
      if (lane.req_ready_o !== 4'b0100) begin
         n_fail++;
         $display("FAIL single_ready got %b exp 0100", lane.req_ready_o);
      end
      @(posedge clk);
      #1;
      lane.req_valid_i = '0;
      @(negedge clk);
      n_checks += 3;
      if (lane.word_o !== 16'h1234) begin
         n_fail++; $display("FAIL single_word got %h exp 1234", lane.word_o);
      end
      if (lane.word_src_o !== 2'd2) begin
         n_fail++; $display("FAIL single_src got %0d exp 2", lane.word_src_o);
      end
      if (lane.word_idle_o !== 1'b0 || lane.word_load_o !== 1'b1) begin
         n_fail++;
         $display("FAIL single_flags got idle=%b load=%b exp 0/1",
                  lane.word_idle_o, lane.word_load_o);
      end
   endtask

   task automatic test_round_robin();
      logic [W-1:0] exp_w;
      int got, budget, k;
      do_reset();
      for (int i = 0; i < N; i++) lane.req_data_i[i*W +: W] = 16'($urandom());
      lane.req_valid_i = '1;
      lane.enable_i = 1'b1;
      got = 0;
      budget = 0;
      while (got < 8 && budget < 200) begin
         @(negedge clk);
         budget++;
         if (|lane.req_ready_o) begin
            k = -1;
            for (int i = 0; i < N; i++) if (lane.req_ready_o[i]) k = i;
            n_checks += 2;
            if ($countones(lane.req_ready_o) != 1) begin
               n_fail++; $display("FAIL rr_onehot got %b", lane.req_ready_o);
            end
            if (k != got % N) begin
               n_fail++; $display("FAIL rr_order got %0d exp %0d", k, got % N);
            end
            exp_w = lane.req_data_i[k*W +: W];
            @(posedge clk);
            #1;
            lane.req_data_i[k*W +: W] = 16'($urandom());
            @(negedge clk);
            n_checks++;
            if (lane.word_o !== exp_w || int'(lane.word_src_o) != k) begin
               n_fail++;
               $display("FAIL rr_word got %h/%0d exp %h/%0d",
                        lane.word_o, lane.word_src_o, exp_w, k);
            end
            got++;
         end
      end
      n_checks++;
      if (got < 8) begin
         n_fail++; $display("FAIL rr_timeout got %0d grants exp 8", got);
      end
   endtask

   task automatic test_disable();
      int c, n;
      bit busy_drop, extra;
      do_reset();
      lane.enable_i = 1'b1;
      c = 0;
      @(negedge clk);
      while (!lane.word_load_o && c < 40) begin
         @(negedge clk);
         c++;
      end
      repeat (5) @(posedge clk);
      #1;
      lane.enable_i = 1'b0;
      n = 0;
      busy_drop = 0;
      do begin
         @(negedge clk);
         n++;
         if (!lane.word_load_o && !lane.busy_o) busy_drop = 1;
      end while (!lane.word_load_o && n < 40);
      n_checks += 3;
      if (n != 12 || busy_drop) begin
         n_fail++;
         $display("FAIL dis_slot_len got %0d drop=%b exp 12/0", n, busy_drop);
      end
      if (lane.busy_o !== 1'b0) begin
         n_fail++; $display("FAIL dis_busy got %b exp 0", lane.busy_o);
      end
      if (lane.word_o !== IDLE || lane.word_idle_o !== 1'b1) begin
         n_fail++;
         $display("FAIL dis_word got %h/%b exp %h/1",
                  lane.word_o, lane.word_idle_o, IDLE);
      end
      extra = 0;
      repeat (40) begin
         @(negedge clk);
         if (lane.word_load_o || lane.busy_o) extra = 1;
      end
      n_checks++;
      if (extra) begin
         n_fail++; $display("FAIL dis_quiet got activity exp none");
      end
   endtask

   task automatic test_reset_mid();
      int c;
      do_reset();
      lane.req_data_i[1*W +: W] = 16'($urandom()) | 16'h0001;
      lane.req_valid_i = 4'b0010;
      lane.enable_i = 1'b1;
      c = 0;
      @(negedge clk);
      while (lane.req_ready_o == '0 && c < 40) begin
         @(negedge clk);
         c++;
      end
      @(posedge clk);
      #1;
      lane.req_valid_i = '0;
      repeat (8) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      n_checks += 3;
      if (lane.word_o !== IDLE || lane.word_idle_o !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_word got %h/%b exp %h/1",
                  lane.word_o, lane.word_idle_o, IDLE);
      end
      if (lane.word_src_o !== '0 || lane.word_load_o !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_src_load got %0d/%b exp 0/0",
                  lane.word_src_o, lane.word_load_o);
      end
      if (lane.busy_o !== 1'b0 || lane.req_ready_o !== '0) begin
         n_fail++;
         $display("FAIL mid_busy got %b/%b exp 0/0",
                  lane.busy_o, lane.req_ready_o);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      lane.req_valid_i = '1;
      c = 0;
      @(negedge clk);
      while (lane.req_ready_o == '0 && c < 40) begin
         @(negedge clk);
         c++;
      end
      n_checks++;
      if (lane.req_ready_o !== 4'b0001) begin
         n_fail++;
         $display("FAIL mid_first_grant got %b exp 0001", lane.req_ready_o);
      end
      @(posedge clk);
      #1;
      lane.req_valid_i = '0;
   endtask

   task automatic test_random();
      logic [N-1:0] rdy;
      int grants;
      do_reset();
      lane.enable_i = 1'b1;
      grants = 0;
      for (int i = 0; i < 800; i++) begin
         @(negedge clk);
         rdy = lane.req_ready_o;
         if (|rdy) grants++;
         @(posedge clk);
         #1;
         for (int k = 0; k < N; k++) begin
            if (!(lane.req_valid_i[k] && !rdy[k])) begin
               lane.req_valid_i[k] = ($urandom_range(0, 2) != 0);
               lane.req_data_i[k*W +: W] = 16'($urandom());
            end
         end
         lane.enable_i = ($urandom_range(0, 19) != 0);
      end
      n_checks++;
      if (grants < 5) begin
         n_fail++; $display("FAIL rand_grants got %0d exp >=5", grants);
      end
   endtask

`ifdef SERIALIZER_SYNC_INSERT_EN
   task automatic test_sync();
      logic [W-1:0] exp_w;
      bit had_grant;
      int s, budget;
      do_reset();
      lane.req_data_i[0 +: W] = 16'($urandom());
      lane.req_valid_i = 4'b0001;
      lane.enable_i = 1'b1;
      had_grant = 0;
      exp_w = '0;
      s = 0;
      budget = 0;
      while (s < 12 && budget < 400) begin
         @(negedge clk);
         budget++;
         if (lane.word_load_o) begin
            n_checks++;
            if (s % SP == SP - 1) begin
               if (lane.word_o !== SYNC || !lane.word_idle_o || had_grant) begin
                  n_fail++;
                  $display("FAIL sync_slot%0d got %h/%b/%b exp %h/1/0",
                           s, lane.word_o, lane.word_idle_o, had_grant, SYNC);
               end
            end else begin
               if (lane.word_o !== exp_w || lane.word_idle_o || !had_grant) begin
                  n_fail++;
                  $display("FAIL data_slot%0d got %h/%b exp %h/0",
                           s, lane.word_o, lane.word_idle_o, exp_w);
               end
            end
            s++;
            had_grant = 0;
         end
         if (lane.req_ready_o[0]) begin
            had_grant = 1;
            exp_w = lane.req_data_i[0 +: W];
            @(posedge clk);
            #1;
            lane.req_data_i[0 +: W] = 16'($urandom());
         end
      end
      n_checks++;
      if (s < 12) begin
         n_fail++; $display("FAIL sync_timeout got %0d slots exp 12", s);
      end
      lane.req_valid_i = '0;
   endtask
`endif

   initial begin
      lane.enable_i = 1'b0;
      lane.req_valid_i = '0;
      lane.req_data_i = '0;
      #1;
      reset = 1'b1;
      test_reset();
      test_idle_slots();
      test_single_req();
      test_round_robin();
      test_disable();
      test_reset_mid();
      test_random();
`ifdef SERIALIZER_SYNC_INSERT_EN
      test_sync();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end
endmodule
